// File: rtl/usr_shift_reg.sv
// usr_shift_reg: parametrised universal shift register.
// Shifts right or left, with optional rotation, or loads a parallel word.
// A shift counter tracks progress through a WIDTH-bit frame and raises a
// registered one-cycle frame_done pulse on the shift that completes it.
module usr_shift_reg #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             rotate,
   input  logic             serial_in_r,
   input  logic             serial_in_l,
   input  logic [WIDTH-1:0] par_in,
   output logic             serial_out_r,
   output logic             serial_out_l,
   output logic [WIDTH-1:0] par_out,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             frame_done
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] q_q,    q_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic             done_q, done_d;
   logic             shifting;

   // Next-state selection: data path, frame counter and frame pulse.
   always_comb begin
      q_d      = q_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shifting = 1'b0;
      if (en) begin
         case (mode)
            MODE_RIGHT: begin
               q_d      = {(rotate ? q_q[0] : serial_in_r), q_q[WIDTH-1:1]};
               shifting = 1'b1;
            end
            MODE_LEFT: begin
               q_d      = {q_q[WIDTH-2:0], (rotate ? q_q[WIDTH-1] : serial_in_l)};
               shifting = 1'b1;
            end
            MODE_LOAD: begin
               q_d   = par_in;
               cnt_d = '0;
            end
            MODE_HOLD: ;
            default: ;
         endcase
         // Any shift, either direction, advances the frame; the last one wraps.
         if (shifting) begin
            if (cnt_q == CNT_LAST) begin
               cnt_d  = '0;
               done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign serial_out_r = q_q[0];
   assign serial_out_l = q_q[WIDTH-1];
   assign par_out      = q_q;
   assign shift_cnt    = cnt_q;
   assign frame_done   = done_q;

endmodule

// File: tb/tb_usr_shift_reg.sv
// Directed self-checking bench for usr_shift_reg at WIDTH=8.
module tb_usr_shift_reg;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         en;
   logic [1:0]   mode;
   logic         rotate;
   logic         serial_in_r;
   logic         serial_in_l;
   logic [W-1:0] par_in;
   logic         serial_out_r;
   logic         serial_out_l;
   logic [W-1:0] par_out;
   logic [2:0]   shift_cnt;
   logic         frame_done;

   int unsigned errors = 0;
   int unsigned checks = 0;

   usr_shift_reg #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .rotate       (rotate),
      .serial_in_r  (serial_in_r),
      .serial_in_l  (serial_in_l),
      .par_in       (par_in),
      .serial_out_r (serial_out_r),
      .serial_out_l (serial_out_l),
      .par_out      (par_out),
      .shift_cnt    (shift_cnt),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] rin_bits;
   logic [7:0] rot_exp [8];
   logic [7:0] sl_exp  [3];

   initial begin
      rin_bits = 8'b0110_1010;   // bit i is the value shifted in on edge i (0,1,0,1,0,1,1,0)
      rot_exp  = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
      sl_exp   = '{8'h4A, 8'h94, 8'h28};

      rst = 1'b0; en = 1'b0; mode = 2'b00; rotate = 1'b0;
      serial_in_r = 1'b0; serial_in_l = 1'b0; par_in = '0;

      // Reset state
      step();
      chk("rst_par_out", 32'(par_out), 32'h00);
      chk("rst_cnt", 32'(shift_cnt), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_sout_r", 32'(serial_out_r), 32'd0);
      chk("rst_sout_l", 32'(serial_out_l), 32'd0);
      rst = 1'b1;

      // Async reset: load FF, shift 3 so the count is nonzero, reset between edges
      en = 1'b1; mode = 2'b11; par_in = 8'hFF;
      step();
      chk("ar_load", 32'(par_out), 32'hFF);
      mode = 2'b01; serial_in_r = 1'b1;
      step(); step(); step();
      chk("ar_cnt_pre", 32'(shift_cnt), 32'd3);
      mode = 2'b00;
      #2 rst = 1'b0;
      #1;
      chk("ar_par_out", 32'(par_out), 32'h00);
      chk("ar_cnt", 32'(shift_cnt), 32'd0);
      chk("ar_done", 32'(frame_done), 32'd0);
      chk("ar_sout_l", 32'(serial_out_l), 32'd0);
      #1 rst = 1'b1;

      // Deserialise right
      mode = 2'b01; rotate = 1'b0;
      for (int i = 0; i < 8; i++) begin
         serial_in_r = rin_bits[i];
         step();
         if (i < 7) begin
            chk("dr_cnt", 32'(shift_cnt), 32'(i + 1));
            chk("dr_done_lo", 32'(frame_done), 32'd0);
         end
      end
      chk("dr_par_out", 32'(par_out), 32'h6A);
      chk("dr_done", 32'(frame_done), 32'd1);
      chk("dr_cnt_wrap", 32'(shift_cnt), 32'd0);
      mode = 2'b00;
      step();
      chk("dr_done_pulse", 32'(frame_done), 32'd0);
      chk("dr_hold", 32'(par_out), 32'h6A);

      // Serialise left
      mode = 2'b11; par_in = 8'hA5;
      step();
      chk("sl_load_msb", 32'(serial_out_l), 32'd1);
      chk("sl_load_cnt", 32'(shift_cnt), 32'd0);
      mode = 2'b10; serial_in_l = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sl_par_out", 32'(par_out), 32'(sl_exp[i]));
         chk("sl_msb", 32'(serial_out_l), 32'(sl_exp[i][7]));
      end
      chk("sl_cnt", 32'(shift_cnt), 32'd3);

      // Rotate right
      mode = 2'b11; par_in = 8'h81;
      step();
      chk("rr_load_cnt", 32'(shift_cnt), 32'd0);
      mode = 2'b01; rotate = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rr_par_out", 32'(par_out), 32'(rot_exp[i]));
         chk("rr_done", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
      end

      // Load mid-frame
      rotate = 1'b0; serial_in_r = 1'b1;
      step(); step(); step(); step(); step();
      chk("lm_cnt_pre", 32'(shift_cnt), 32'd5);
      mode = 2'b11; par_in = 8'h3C;
      step();
      chk("lm_par_out", 32'(par_out), 32'h3C);
      chk("lm_cnt", 32'(shift_cnt), 32'd0);
      chk("lm_done", 32'(frame_done), 32'd0);
      mode = 2'b01;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("lm_done_lo", 32'(frame_done), 32'd0);
      end
      step();
      chk("lm_done_hi", 32'(frame_done), 32'd1);
      chk("lm_par_full", 32'(par_out), 32'hFF);

      // Enable low right after a frame: pulse drops, state holds
      en = 1'b0;
      step();
      chk("en_done_drop", 32'(frame_done), 32'd0);
      chk("en_hold_par", 32'(par_out), 32'hFF);
      en = 1'b1;

      // Enable gating mid-stream
      serial_in_r = 1'b0;
      step(); step(); step(); step();
      chk("eg_par_pre", 32'(par_out), 32'h0F);
      chk("eg_cnt_pre", 32'(shift_cnt), 32'd4);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("eg_par_frz", 32'(par_out), 32'h0F);
         chk("eg_cnt_frz", 32'(shift_cnt), 32'd4);
         chk("eg_done_lo", 32'(frame_done), 32'd0);
      end
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("eg_done_early", 32'(frame_done), 32'd0);
      end
      step();
      chk("eg_done", 32'(frame_done), 32'd1);
      chk("eg_par_out", 32'(par_out), 32'h00);
      chk("eg_cnt", 32'(shift_cnt), 32'd0);

      // Rotate left
      mode = 2'b11; par_in = 8'h81;
      step();
      mode = 2'b10; rotate = 1'b1;
      step();
      chk("rl_par_out", 32'(par_out), 32'h03);
      chk("rl_sout_r", 32'(serial_out_r), 32'd1);
      chk("rl_cnt", 32'(shift_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usr_shift_reg.md
# usr_shift_reg

Parametrised universal shift register, the successor to the fixed serial-in/serial-out register. Supports a configurable width, shifting in either direction, optional rotation, and parallel load. A shift counter and a one-cycle `frame_done` pulse mark each completed WIDTH-bit frame. It sits between serial links and word-wide datapath logic, serving as both a serialiser and a deserialiser.

## Interface
- `WIDTH`, default 8: register width in bits; legal range ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: width of `shift_cnt`. Localparam, not overridable.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  clock enable. When 0, all state holds.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `rotate`  in  1  when 1, a shift recirculates the outgoing bit instead of taking a serial input.
- `serial_in_r`  in  1  bit entering the MSB on a right shift.
- `serial_in_l`  in  1  bit entering the LSB on a left shift.
- `par_in`  in  WIDTH  parallel load data.
- `serial_out_r`  out  1  equals `q[0]`.
- `serial_out_l`  out  1  equals `q[WIDTH-1]`.
- `par_out`  out  WIDTH  register contents `q`.
- `shift_cnt`  out  CNT_W  number of shifts since the last frame boundary, load, or reset.
- `frame_done`  out  1  registered one-cycle pulse marking a completed frame.

## Operation
- Reset (`rst`=0) clears `q`, `shift_cnt` and `frame_done` to 0 immediately, without waiting for a clock edge. Consequently `serial_out_r`, `serial_out_l` and `par_out` also read 0 during reset.
- Reset deassertion is not edge-sensitive. The first rising edge with `rst`=1 performs normal operation.
- Behaviour on a rising edge with `en`=1:
  - 00 (hold): `q` and `shift_cnt` hold.
  - 01 (shift right): `q <= {rotate ? q[0] : serial_in_r, q[WIDTH-1:1]}`.
  - 10 (shift left): `q <= {q[WIDTH-2:0], rotate ? q[WIDTH-1] : serial_in_l}`.
  - 11 (parallel load): `q <= par_in`, `shift_cnt <= 0`.
- Shift counter:
  - Every shift (mode 01 or 10, either direction, rotating or not) increments `shift_cnt`.
  - On a shift with `shift_cnt == WIDTH-1`, `shift_cnt` wraps to 0 and `frame_done` is set to 1.
  - Mixing directions within one frame is legal; every shift counts toward the frame.
- `frame_done` is 0 on every edge that does not complete a frame, including edges with `en`=0, hold, and load.
- A load in the middle of a frame aborts it: the count restarts at 0 and no `frame_done` is produced for the aborted frame.
- `en`=0 overrides `mode`. `q` and `shift_cnt` hold, and `frame_done` drops to 0 on that edge.
- `serial_out_r`, `serial_out_l` and `par_out` are combinational taps of `q` with no added logic.

## Timing
- Serial-to-serial latency: a bit presented on `serial_in_r` appears on `serial_out_r` after exactly WIDTH right-shift edges. Left shifts behave symmetrically.
- Parallel load: `par_out` shows `par_in` immediately after the load edge (latency 1).
- `frame_done` is high for exactly one cycle, starting at the edge of the WIDTH-th shift. The assembled word is valid on `par_out` in that same cycle.
- Back-to-back frames are supported with no gap: continuous shifting produces a `frame_done` pulse every WIDTH enabled shift cycles.
- An asynchronous reset asserted mid-frame discards the partial frame. No `frame_done` is produced for it.

## Test plan
- **Async reset:** load 8'hFF, then pull `rst` low between clock edges → `par_out`=8'h00, `shift_cnt`=0 and `frame_done`=0 before the next edge.
- **Deserialise right:** WIDTH=8, `rotate`=0. After reset, apply 8 right shifts with `serial_in_r` = 0,1,0,1,0,1,1,0 → `par_out`=8'h6A. `frame_done`=1 for one cycle after the 8th edge, and `shift_cnt`=0.
- **Serialise left:** load 8'hA5, then apply 3 left shifts with `serial_in_l`=0 → `serial_out_l` reads 1,0,1,0 across the load cycle and each shift cycle; final `par_out`=8'h28 and `shift_cnt`=3.
- **Rotate right:** load 8'h81, set `rotate`=1, apply 8 right shifts → after the 1st shift `par_out`=8'hC0; after the 8th shift `par_out`=8'h81 with a single `frame_done` pulse.
- **Load mid-frame:** apply 5 shifts, then a load of 8'h3C → `shift_cnt`=0 and no `frame_done` pulse; the next `frame_done` occurs only after 8 further shifts.
- **Enable gating:** during a shift stream, hold `en`=0 for 3 cycles → `par_out` and `shift_cnt` are frozen and `frame_done`=0; the frame completes 3 cycles later than it would without gating.
